// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder: FSM encoding, MMIO slot, wait-state defaults.
// The MMIO LED register is enabled by defining MEM_RESP_MMIO_EN.
package mem_resp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_ACK    = 2'd3
   } state_e;

   localparam int         DEFAULT_WAIT_CYCLES = 1;
   localparam int         WAIT_CNT_W          = 4;
   localparam logic [7:0] MMIO_ADDR           = 8'hFF;

   // Value loaded into the wait counter on entry to WAIT; zero wait states never enter WAIT.
   function automatic logic [WAIT_CNT_W-1:0] wait_load(input int wait_cycles);
      if (wait_cycles > 0) begin
         return WAIT_CNT_W'(wait_cycles - 1);
      end
      return '0;
   endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Synchronous-write / synchronous-read storage for the memory responder; contents survive reset.
// Read data is registered and only updates when rd_en is high.
module mem_resp_array
   import mem_resp_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] store [2**ADDR_W];
   logic [DATA_W-1:0] rd_data_q;

   always_ff @(posedge clock) begin
      if (wr_en) begin
         store[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= store[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding req/ack memory responder with programmable wait states in front of a 2**ADDR_W store.
// Define MEM_RESP_MMIO_EN to map the all-ones address onto the led_out register instead of the store.
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              ack,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic [DATA_W-1:0] led_out
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

   state_e                  state_q, state_d;
   logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic                    we_q, we_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [DATA_W-1:0]       wdata_q, wdata_d;
   logic [DATA_W-1:0]       rdata_q, rdata_d;

   logic                    mmio_hit;
   logic [DATA_W-1:0]       mmio_rdata;
   logic                    arr_wr_en;
   logic                    arr_rd_en;
   logic [DATA_W-1:0]       arr_rd_data;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         rdata_q    <= rdata_d;
      end
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               we_d    = we;
               addr_d  = addr;
               wdata_d = wdata;
               if (WAIT_CYCLES > 0) begin
                  state_d    = ST_WAIT;
                  wait_cnt_d = WAIT_LOAD;
               end else begin
                  state_d = ST_ACCESS;
               end
            end
         end
         ST_WAIT: begin
            if (wait_cnt_q == '0) begin
               state_d = ST_ACCESS;
            end else begin
               wait_cnt_d = wait_cnt_q - 1'b1;
            end
         end
         ST_ACCESS: state_d = ST_ACK;
         ST_ACK:    state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ack  = 1'b0;
      busy = 1'b1;
      case (state_q)
         ST_IDLE: busy = 1'b0;
         ST_ACK:  ack  = 1'b1;
         default: ;
      endcase
   end

   // The store is read at request acceptance, so its registered output is ready by ACCESS.
   assign arr_rd_en = (state_q == ST_IDLE) && req && !we;
   assign arr_wr_en = (state_q == ST_ACCESS) && we_q && !mmio_hit;

   always_comb begin
      rdata_d = rdata_q;
      if (state_q == ST_ACCESS && !we_q) begin
         rdata_d = mmio_hit ? mmio_rdata : arr_rd_data;
      end
   end

   assign rdata = rdata_q;

`ifdef MEM_RESP_MMIO_EN
   localparam logic [ADDR_W-1:0] MMIO_SLOT = '1;

   logic [DATA_W-1:0] led_q, led_d;

   assign mmio_hit = (addr_q == MMIO_SLOT);

   always_comb begin
      led_d = led_q;
      if (state_q == ST_ACCESS && we_q && mmio_hit) begin
         led_d = wdata_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         led_q <= '0;
      end else begin
         led_q <= led_d;
      end
   end

   assign mmio_rdata = led_q;
   assign led_out    = led_q;
`else
   assign mmio_hit   = 1'b0;
   assign mmio_rdata = '0;
   assign led_out    = '0;
`endif

   mem_resp_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clock   (clock),
      .wr_en   (arr_wr_en),
      .wr_addr (addr_q),
      .wr_data (wdata_q),
      .rd_en   (arr_rd_en),
      .rd_addr (addr),
      .rd_data (arr_rd_data)
   );

endmodule
